l2_cache_sa: RTL and testbench



---
 rtl/l2_cache_sa.sv | 180 ++++++++++++++++++
 tb/tb_l2_cache_sa.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_sa.sv
// Set-associative write-back/write-allocate L2 cache between one L1 and main memory.
// Tree pseudo-LRU replacement and saturating hit/miss counters.
module l2_cache_sa #(
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int SET_BITS = 4,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              L2_read,
  input  logic              L2_write,
  input  logic [ADDR_W-1:0] L2_addr,
  input  logic [LINE_W-1:0] L2_wdata,
  output logic [LINE_W-1:0] L2_rdata,
  output logic              L2_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  // state  | meaning
  // IDLE   | one cycle after reset release
  // CMPTAG | tag compare; hits complete here with zero latency
  // WRTMEM | write dirty victim back to memory
  // RDMEM  | fetch missing line into the victim way

  localparam int SETS   = 1 << SET_BITS;
  localparam int TAG_W  = ADDR_W - SET_BITS;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS == 4) ? 3 : 1;

  if (WAYS != 1 && WAYS != 2 && WAYS != 4) begin : g_bad_ways
    $error("l2_cache_sa: WAYS must be 1, 2 or 4");
  end
  if (SET_BITS < 1 || SET_BITS > 8) begin : g_bad_sets
    $error("l2_cache_sa: SET_BITS must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, CMPTAG, WRTMEM, RDMEM} state_t;

  state_t              state;
  logic [WAY_W-1:0]    victim_way;
  logic                missed;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [PLRU_W-1:0]   plru_q  [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                req_valid;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                has_free;
  logic [WAY_W-1:0]    free_way;
  logic [WAY_W-1:0]    plru_victim;
  logic [PLRU_W-1:0]   plru_next;
  logic [WAY_W-1:0]    victim_sel;

  assign set_idx   = L2_addr[SET_BITS-1:0];
  assign req_tag   = L2_addr[ADDR_W-1:SET_BITS];
  assign req_valid = L2_read ^ L2_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!has_free && !valid_q[set_idx][w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  // Each PLRU bit points toward the least recently used side.
  if (WAYS == 4) begin : g_plru4
    always_comb begin
      plru_victim = plru_q[set_idx][0] ? {1'b1, plru_q[set_idx][2]}
                                       : {1'b0, plru_q[set_idx][1]};
      plru_next    = plru_q[set_idx];
      plru_next[0] = ~hit_way[1];
      if (hit_way[1]) plru_next[2] = ~hit_way[0];
      else            plru_next[1] = ~hit_way[0];
    end
  end else if (WAYS == 2) begin : g_plru2
    assign plru_victim = plru_q[set_idx][0];
    assign plru_next   = ~hit_way[0];
  end else begin : g_plru1
    assign plru_victim = '0;
    assign plru_next   = '0;
  end

  assign victim_sel = has_free ? free_way : plru_victim;

  assign L2_ready  = (state == CMPTAG) && req_valid && hit;
  assign L2_rdata  = L2_ready ? data_q[set_idx][hit_way] : '0;
  assign mem_write = (state == WRTMEM);
  assign mem_read  = (state == RDMEM);
  assign mem_addr  = mem_write ? {tag_q[set_idx][victim_way], set_idx} : L2_addr;
  assign mem_wdata = mem_write ? data_q[set_idx][victim_way] : '0;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state      <= IDLE;
      victim_way <= '0;
      missed     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: state <= CMPTAG;
        CMPTAG: begin
          if (req_valid) begin
            if (hit) begin
              if (L2_write) dirty_q[set_idx][hit_way] <= 1'b1;
              plru_q[set_idx] <= plru_next;
              missed          <= 1'b0;
              if (!missed && (hit_count != {CNT_W{1'b1}})) hit_count <= hit_count + 1'b1;
            end else begin
              victim_way <= victim_sel;
              missed     <= 1'b1;
              if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
              if (valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel]) state <= WRTMEM;
              else                                                              state <= RDMEM;
            end
          end
        end
        WRTMEM: begin
          if (mem_ready) begin
            dirty_q[set_idx][victim_way] <= 1'b0;
            state                        <= RDMEM;
          end
        end
        RDMEM: begin
          if (mem_ready) begin
            valid_q[set_idx][victim_way] <= 1'b1;
            dirty_q[set_idx][victim_way] <= 1'b0;
            state                        <= CMPTAG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line and tag storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (L2_ready && L2_write) begin
      data_q[set_idx][hit_way] <= L2_wdata;
    end else if ((state == RDMEM) && mem_ready) begin
      data_q[set_idx][victim_way] <= mem_rdata;
      tag_q[set_idx][victim_way]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_l2_cache_sa.sv
// Bench for l2_cache_sa: directed scenarios plus randomized traffic against a
// true-LRU line-level model (identical to tree PLRU for two ways).
module tb_l2_cache_sa;
  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          proc_reset_n;
  logic          L2_read, L2_write;
  logic [AW-1:0] L2_addr;
  logic [LW-1:0] L2_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;

  logic [LW-1:0] L2_rdata, mem_wdata;
  logic          L2_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   hit_count, miss_count;

  logic [LW-1:0] s_L2_rdata, s_mem_wdata;
  logic          s_L2_ready, s_mem_read, s_mem_write;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_hit_count, s_miss_count;

  always #5 clk = ~clk;

  l2_cache_sa dut (
    .clk(clk), .proc_reset_n(proc_reset_n), .L2_read(L2_read), .L2_write(L2_write),
    .L2_addr(L2_addr), .L2_wdata(L2_wdata), .L2_rdata(L2_rdata), .L2_ready(L2_ready),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  l2_cache_sa #(.CNT_W(4)) dut_sat (
    .clk(clk), .proc_reset_n(proc_reset_n), .L2_read(L2_read), .L2_write(L2_write),
    .L2_addr(L2_addr), .L2_wdata(L2_wdata), .L2_rdata(s_L2_rdata), .L2_ready(s_L2_ready),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 16 sets x 2 ways of whole lines, plus a sparse memory.
  bit            m_valid [16][2];
  bit            m_dirty [16][2];
  logic [AW-1:0] m_addr  [16][2];
  logic [LW-1:0] m_data  [16][2];
  int            m_lru   [16];
  int            m_hits, m_misses;
  logic [LW-1:0] mem_q [logic [AW-1:0]];
  logic [AW-1:0] last_wb_addr;
  logic [LW-1:0] last_wb_data;

  function automatic logic [LW-1:0] mem_get(input logic [AW-1:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return {4{{4'h0, a} ^ 32'h5A5A_0000}};
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic clear_model;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      m_lru[s] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic apply_reset;
    proc_reset_n = 1'b0;
    L2_read = 1'b0; L2_write = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
    clear_model();
    @(posedge clk); #1;
  endtask

  // One L1 transaction, serviced by the memory model with the given latencies.
  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                        input int rd_lat, input int wr_lat, output bit was_hit);
    int s, v, exp_rdy, wr_seen, rd_seen;
    bit hit, wb, done;
    logic [AW-1:0] wb_a;
    logic [LW-1:0] wb_d, exp_line;
    s = int'(a[3:0]);
    hit = 1'b0; v = 0; wb = 1'b0; wb_a = '0; wb_d = '0;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_addr[s][w] == a) begin hit = 1'b1; v = w; end
    if (!hit) begin
      if (!m_valid[s][0]) v = 0;
      else if (!m_valid[s][1]) v = 1;
      else v = m_lru[s];
      wb   = m_valid[s][v] && m_dirty[s][v];
      wb_a = m_addr[s][v];
      wb_d = m_data[s][v];
    end
    exp_line = hit ? m_data[s][v] : mem_get(a);
    exp_rdy  = hit ? 0 : 1 + rd_lat + (wb ? wr_lat : 0);

    L2_read = !wr; L2_write = wr; L2_addr = a; L2_wdata = wd;
    wr_seen = 0; rd_seen = 0; done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!L2_ready && L2_rdata !== '0) begin
        failures++; $display("FAIL rdata_idle addr=%h got=%h want=0", a, L2_rdata);
      end
      if (!mem_write && mem_wdata !== '0) begin
        failures++; $display("FAIL wdata_idle addr=%h got=%h want=0", a, mem_wdata);
      end
      if (L2_ready) begin
        done = 1'b1;
        checks++;
        if (cyc !== exp_rdy || s_L2_ready !== 1'b1) begin
          failures++; $display("FAIL latency addr=%h got=%0d want=%0d", a, cyc, exp_rdy);
        end
        if (!wr) begin
          checks++;
          if (L2_rdata !== exp_line || s_L2_rdata !== exp_line) begin
            failures++; $display("FAIL rdata addr=%h got=%h want=%h", a, L2_rdata, exp_line);
          end
        end
      end else if (mem_write) begin
        wr_seen++;
        last_wb_addr = mem_addr;
        last_wb_data = mem_wdata;
        checks++;
        if (!wb || mem_addr !== wb_a || mem_wdata !== wb_d || s_mem_write !== 1'b1 ||
            s_mem_addr !== wb_a || s_mem_wdata !== wb_d) begin
          failures++; $display("FAIL writeback addr=%h got=%h/%h want=%h/%h wb=%0d",
                               a, mem_addr, mem_wdata, wb_a, wb_d, wb);
        end
        mem_ready = (wr_seen == wr_lat);
      end else if (mem_read) begin
        rd_seen++;
        checks++;
        if (mem_addr !== a || s_mem_read !== 1'b1 || s_mem_addr !== a) begin
          failures++; $display("FAIL fill_addr got=%h want=%h", mem_addr, a);
        end
        mem_rdata = mem_get(a);
        mem_ready = (rd_seen == rd_lat);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    L2_read = 1'b0; L2_write = 1'b0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL timeout addr=%h got=no_ready want=ready", a);
    end
    checks++;
    if (wr_seen !== (wb ? wr_lat : 0) || rd_seen !== (hit ? 0 : rd_lat)) begin
      failures++; $display("FAIL mem_cycles addr=%h got=wr%0d/rd%0d want=wr%0d/rd%0d", a,
                           wr_seen, rd_seen, wb ? wr_lat : 0, hit ? 0 : rd_lat);
    end

    if (wb) mem_q[wb_a] = wb_d;
    if (!hit) begin
      m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0;
      m_addr[s][v] = a;     m_data[s][v] = mem_get(a);
      m_misses++;
    end else m_hits++;
    if (wr) begin m_data[s][v] = wd; m_dirty[s][v] = 1'b1; end
    m_lru[s] = 1 - v;
    was_hit = hit;

    checks++;
    if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
      failures++; $display("FAIL counters got=%0d/%0d want=%0d/%0d", hit_count, miss_count, m_hits, m_misses);
    end
    checks++;
    if (s_hit_count !== 4'(sat15(m_hits)) || s_miss_count !== 4'(sat15(m_misses))) begin
      failures++; $display("FAIL sat_counters got=%0d/%0d want=%0d/%0d", s_hit_count, s_miss_count,
                           sat15(m_hits), sat15(m_misses));
    end
  endtask

  task automatic test_reset;
    proc_reset_n = 1'b0;
    L2_read = 1'b1; L2_write = 1'b0; L2_addr = 28'h13; L2_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({L2_ready, mem_read, mem_write} !== 3'b0 || L2_rdata !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b want=000", {L2_ready, mem_read, mem_write});
    end
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0 || s_hit_count !== 4'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hit_count, miss_count);
    end
    proc_reset_n = 1'b1;
    #1;
    checks++;
    if ({L2_ready, mem_read, mem_write} !== 3'b0) begin
      failures++; $display("FAIL idle_outputs got=%b want=000", {L2_ready, mem_read, mem_write});
    end
    @(posedge clk); #1;
    clear_model();
    L2_read = 1'b0;
  endtask

  task automatic test_cold_read;
    bit h;
    access(1'b0, 28'h13, '0, 3, 1, h);
    checks++;
    if (h !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd1) begin
      failures++; $display("FAIL cold_read got=hit%0d h%0d m%0d want=hit0 h0 m1", h, hit_count, miss_count);
    end
  endtask

  task automatic test_assoc;
    bit h1, h2, h3;
    access(1'b0, 28'h23, '0, 2, 1, h1);
    access(1'b0, 28'h13, '0, 2, 1, h2);
    access(1'b0, 28'h23, '0, 2, 1, h3);
    checks++;
    if ({h1, h2, h3} !== 3'b011 || hit_count !== 32'd2) begin
      failures++; $display("FAIL assoc got=%b h%0d want=011 h2", {h1, h2, h3}, hit_count);
    end
  endtask

  task automatic test_plru_dirty;
    bit h;
    logic [LW-1:0] w_line;
    w_line = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
    last_wb_addr = '0; last_wb_data = '0;
    access(1'b1, 28'h13, w_line, 2, 2, h);
    access(1'b0, 28'h23, '0, 2, 2, h);
    access(1'b0, 28'h33, '0, 2, 3, h);
    checks++;
    if (last_wb_addr !== 28'h13 || last_wb_data !== w_line) begin
      failures++; $display("FAIL plru_evict got=%h/%h want=%h/%h", last_wb_addr, last_wb_data, 28'h13, w_line);
    end
  endtask

  task automatic test_illegal;
    int h0, m0;
    bit h;
    h0 = m_hits; m0 = m_misses;
    L2_read = 1'b1; L2_write = 1'b1; L2_addr = 28'h45;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin L2_read = 1'b0; L2_write = 1'b0; end
      @(negedge clk);
      checks++;
      if ({L2_ready, mem_read, mem_write} !== 3'b0) begin
        failures++; $display("FAIL illegal_req cyc=%0d got=%b want=000", c, {L2_ready, mem_read, mem_write});
      end
      @(posedge clk); #1;
    end
    checks++;
    if (hit_count !== 32'(h0) || miss_count !== 32'(m0)) begin
      failures++; $display("FAIL illegal_counters got=%0d/%0d want=%0d/%0d", hit_count, miss_count, h0, m0);
    end
    access(1'b0, 28'h33, '0, 1, 1, h);
  endtask

  task automatic test_random;
    bit h;
    logic [AW-1:0] a;
    for (int i = 0; i < 80; i++) begin
      a = AW'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 1) ? 3 : 5));
      access(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(1, 4), $urandom_range(1, 4), h);
    end
  endtask

  task automatic test_reset_mid_wb;
    bit h, seen;
    apply_reset();
    access(1'b1, 28'h13, {4{32'h7777_1111}}, 1, 1, h);
    access(1'b0, 28'h23, '0, 1, 1, h);
    L2_read = 1'b1; L2_write = 1'b0; L2_addr = 28'h33;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_write) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL wb_start got=no_mem_write want=mem_write");
    end
    #2 proc_reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_read, s_mem_write} !== 3'b0) begin
      failures++; $display("FAIL reset_drop got=%b want=000", {mem_write, mem_read, s_mem_write});
    end
    L2_read = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    clear_model();
    @(posedge clk); #1;
    access(1'b0, 28'h13, '0, 2, 2, h);
    checks++;
    if (h !== 1'b0) begin
      failures++; $display("FAIL reread_after_reset got=hit want=miss");
    end
  endtask

  task automatic test_saturation;
    bit h;
    apply_reset();
    access(1'b0, 28'h13, '0, 1, 1, h);
    for (int i = 0; i < 20; i++) access(1'b0, 28'h13, '0, 1, 1, h);
    checks++;
    if (s_hit_count !== 4'd15 || hit_count !== 32'd20 || s_miss_count !== 4'd1) begin
      failures++; $display("FAIL saturation got=%0d/%0d want=15/20", s_hit_count, hit_count);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_assoc();
    test_plru_dirty();
    test_illegal();
    test_random();
    test_reset_mid_wb();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
